// File: rtl/ram16_pkg.sv
// Shared definitions for the clients of the 16-read/1-write replicated RAM.
package ram16_pkg;
  localparam int BLOCKSIZE = 10;
  localparam int AW        = BLOCKSIZE + 1;
  localparam int DW        = 32;
  localparam int NPORT     = 16;
  localparam int LEN_W     = 5;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DRAIN
  } gather_state_t;
endpackage

// File: rtl/ram_gather_buf.sv
// Capture buffer for one burst: snapshots all 16 RAM read ports in a single
// cycle and presents one word at a time selected by the drain index.
module ram_gather_buf
  import ram16_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic                       clk,
  input  logic                       load,
  input  logic [NPORT-1:0][DW-1:0]   din,
  input  logic [3:0]                 idx,
  output logic [DW-1:0]              dout
);

  logic [DW-1:0] word_q [NPORT];

  // Load every slot together; the buffer holds data only, so it has no reset
  always_ff @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < NPORT; k++) word_q[k] <= din[k];
    end
  end

  assign dout = word_q[idx];

endmodule

// File: rtl/ram_burst_read_gather.sv
// Burst read gather: accepts (base, len), fires all 16 RAM read ports at
// consecutive addresses, captures the returned words once the read latency
// has elapsed and streams them out one per handshake with a last flag.
module ram_burst_read_gather
  import ram16_pkg::*;
#(
  parameter int BLOCKSIZE = 10,
  parameter int DW        = 32,
  parameter int RD_LAT    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [BLOCKSIZE:0] req_base,
  input  logic [LEN_W-1:0]   req_len,
  output logic [BLOCKSIZE:0] r_addr_1,
  output logic [BLOCKSIZE:0] r_addr_2,
  output logic [BLOCKSIZE:0] r_addr_3,
  output logic [BLOCKSIZE:0] r_addr_4,
  output logic [BLOCKSIZE:0] r_addr_5,
  output logic [BLOCKSIZE:0] r_addr_6,
  output logic [BLOCKSIZE:0] r_addr_7,
  output logic [BLOCKSIZE:0] r_addr_8,
  output logic [BLOCKSIZE:0] r_addr_9,
  output logic [BLOCKSIZE:0] r_addr_10,
  output logic [BLOCKSIZE:0] r_addr_11,
  output logic [BLOCKSIZE:0] r_addr_12,
  output logic [BLOCKSIZE:0] r_addr_13,
  output logic [BLOCKSIZE:0] r_addr_14,
  output logic [BLOCKSIZE:0] r_addr_15,
  output logic [BLOCKSIZE:0] r_addr_16,
  input  logic [DW-1:0]      r_dout_1,
  input  logic [DW-1:0]      r_dout_2,
  input  logic [DW-1:0]      r_dout_3,
  input  logic [DW-1:0]      r_dout_4,
  input  logic [DW-1:0]      r_dout_5,
  input  logic [DW-1:0]      r_dout_6,
  input  logic [DW-1:0]      r_dout_7,
  input  logic [DW-1:0]      r_dout_8,
  input  logic [DW-1:0]      r_dout_9,
  input  logic [DW-1:0]      r_dout_10,
  input  logic [DW-1:0]      r_dout_11,
  input  logic [DW-1:0]      r_dout_12,
  input  logic [DW-1:0]      r_dout_13,
  input  logic [DW-1:0]      r_dout_14,
  input  logic [DW-1:0]      r_dout_15,
  input  logic [DW-1:0]      r_dout_16,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DW-1:0]      out_data,
  output logic               out_last,
  output logic               busy,
  output logic [15:0]        bursts_done
);

  gather_state_t            state_q, state_d;
  logic                     rdy_q;
  logic [1:0]               wcnt_q;
  logic [LEN_W-1:0]         len_q;
  logic [LEN_W-1:0]         len_eff;
  logic [3:0]               idx_q;
  logic [15:0]              done_q;
  logic [BLOCKSIZE:0]       addr_q [NPORT];
  logic [NPORT-1:0][DW-1:0] rd_data;
  logic [DW-1:0]            buf_word;
  logic                     accept;
  logic                     load;
  logic                     last;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign len_eff   = (req_len > 5'd16) ? 5'd16 : req_len;
  // rdy_q keeps req_ready low during reset and for the cycle after a null burst
  assign req_ready = (state_q == IDLE) && rdy_q;
  assign accept    = req_valid && req_ready;
  assign last      = ({1'b0, idx_q} == (len_q - 5'd1));

  assign out_valid   = (state_q == DRAIN);
  assign out_last    = out_valid && last;
  assign out_data    = out_valid ? buf_word : '0;
  assign busy        = (state_q != IDLE);
  assign bursts_done = done_q;

  assign r_addr_1  = addr_q[0];
  assign r_addr_2  = addr_q[1];
  assign r_addr_3  = addr_q[2];
  assign r_addr_4  = addr_q[3];
  assign r_addr_5  = addr_q[4];
  assign r_addr_6  = addr_q[5];
  assign r_addr_7  = addr_q[6];
  assign r_addr_8  = addr_q[7];
  assign r_addr_9  = addr_q[8];
  assign r_addr_10 = addr_q[9];
  assign r_addr_11 = addr_q[10];
  assign r_addr_12 = addr_q[11];
  assign r_addr_13 = addr_q[12];
  assign r_addr_14 = addr_q[13];
  assign r_addr_15 = addr_q[14];
  assign r_addr_16 = addr_q[15];

  assign rd_data[0]  = r_dout_1;
  assign rd_data[1]  = r_dout_2;
  assign rd_data[2]  = r_dout_3;
  assign rd_data[3]  = r_dout_4;
  assign rd_data[4]  = r_dout_5;
  assign rd_data[5]  = r_dout_6;
  assign rd_data[6]  = r_dout_7;
  assign rd_data[7]  = r_dout_8;
  assign rd_data[8]  = r_dout_9;
  assign rd_data[9]  = r_dout_10;
  assign rd_data[10] = r_dout_11;
  assign rd_data[11] = r_dout_12;
  assign rd_data[12] = r_dout_13;
  assign rd_data[13] = r_dout_14;
  assign rd_data[14] = r_dout_15;
  assign rd_data[15] = r_dout_16;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state and buffer load strobe
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE:    if (accept && (len_eff != '0)) state_d = WAIT;
      WAIT:    if (wcnt_q == 2'd0) begin
                 load    = 1'b1;
                 state_d = DRAIN;
               end
      DRAIN:   if (out_ready && last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address generator: all 16 ports driven on every accept, wrapping mod 2^AW
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NPORT; k++) addr_q[k] <= '0;
    end else if (accept) begin
      for (int k = 0; k < NPORT; k++) addr_q[k] <= req_base + k[BLOCKSIZE:0];
    end
  end

  // Burst bookkeeping: ready gating, latency countdown, length, drain index, burst count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_q  <= 1'b0;
      wcnt_q <= '0;
      len_q  <= '0;
      idx_q  <= '0;
      done_q <= '0;
    end else begin
      rdy_q <= !(accept && (len_eff == '0));
      if (accept) begin
        wcnt_q <= 2'(RD_LAT);
        len_q  <= len_eff;
      end else if ((state_q == WAIT) && (wcnt_q != 2'd0)) begin
        wcnt_q <= wcnt_q - 2'd1;
      end
      if (load)                        idx_q <= '0;
      else if (out_valid && out_ready) idx_q <= idx_q + 4'd1;
      if (out_valid && out_ready && last) done_q <= sat_inc(done_q);
    end
  end

  ram_gather_buf #(
    .DW(DW)
  ) u_buf (
    .clk (clk),
    .load(load),
    .din (rd_data),
    .idx (idx_q),
    .dout(buf_word)
  );

endmodule

// File: tb/tb_ram_burst_read_gather.sv
// Directed bench: three gather instances (read latency 1, 0 and 3), each fed by
// its own RAM model holding mem[a] = a*3.
module tb_ram_burst_read_gather;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [10:0] req_base = '0;
  logic [4:0]  req_len = '0;
  logic        out_ready = 1'b0;
  int          sel = 0;

  logic [2:0]        rr, ov, ol, bsy;
  logic [2:0][31:0]  od;
  logic [2:0][15:0]  bd;

  int total = 0;
  int bad = 0;
  int exp_bd [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : (g == 1) ? 0 : 3;
    localparam int DI  = (LAT == 0) ? 0 : LAT - 1;
    logic [10:0] a [16];
    logic [31:0] d [16];
    logic [10:0] dly [4][16];

    always @(posedge clk) begin
      dly[0] <= a;
      for (int s = 1; s < 4; s++) dly[s] <= dly[s-1];
    end

    always_comb begin
      for (int k = 0; k < 16; k++)
        d[k] = (LAT == 0) ? {21'd0, a[k]} * 32'd3 : {21'd0, dly[DI][k]} * 32'd3;
    end

    ram_burst_read_gather #(.BLOCKSIZE(10), .DW(32), .RD_LAT(LAT)) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid && (sel == g)), .req_ready(rr[g]),
      .req_base(req_base), .req_len(req_len),
      .r_addr_1(a[0]),   .r_addr_2(a[1]),   .r_addr_3(a[2]),   .r_addr_4(a[3]),
      .r_addr_5(a[4]),   .r_addr_6(a[5]),   .r_addr_7(a[6]),   .r_addr_8(a[7]),
      .r_addr_9(a[8]),   .r_addr_10(a[9]),  .r_addr_11(a[10]), .r_addr_12(a[11]),
      .r_addr_13(a[12]), .r_addr_14(a[13]), .r_addr_15(a[14]), .r_addr_16(a[15]),
      .r_dout_1(d[0]),   .r_dout_2(d[1]),   .r_dout_3(d[2]),   .r_dout_4(d[3]),
      .r_dout_5(d[4]),   .r_dout_6(d[5]),   .r_dout_7(d[6]),   .r_dout_8(d[7]),
      .r_dout_9(d[8]),   .r_dout_10(d[9]),  .r_dout_11(d[10]), .r_dout_12(d[11]),
      .r_dout_13(d[12]), .r_dout_14(d[13]), .r_dout_15(d[14]), .r_dout_16(d[15]),
      .out_valid(ov[g]), .out_ready(out_ready), .out_data(od[g]), .out_last(ol[g]),
      .busy(bsy[g]), .bursts_done(bd[g])
    );
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int u, input logic [10:0] base, input logic [4:0] len);
    sel = u;
    req_base = base;
    req_len = len;
    req_valid = 1'b1;
    cyc();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (rr !== 3'b000) begin bad++; $display("FAIL reset_ready act=%b req=000", rr); end
    total++; if (ov !== 3'b000 || ol !== 3'b000) begin bad++; $display("FAIL reset_valid_last act=%b/%b req=000/000", ov, ol); end
    total++; if (bsy !== 3'b000) begin bad++; $display("FAIL reset_busy act=%b req=000", bsy); end
    total++; if (bd[0] !== 16'd0 || od[0] !== 32'd0) begin bad++; $display("FAIL reset_count_data act=%h/%h req=0/0", bd[0], od[0]); end
    total++; if (g_dut[0].a[15] !== 11'd0) begin bad++; $display("FAIL reset_addr16 act=%h req=000", g_dut[0].a[15]); end
    rst = 1'b1;
    #1;
    total++; if (rr[0] !== 1'b0) begin bad++; $display("FAIL release_ready_early act=%b req=0", rr[0]); end
    cyc();
    total++; if (rr !== 3'b111) begin bad++; $display("FAIL release_ready act=%b req=111", rr); end
  endtask

  task automatic test_basic();
    int n;
    out_ready = 1'b1;
    total++; if (rr[0] !== 1'b1) begin bad++; $display("FAIL basic_ready act=%b req=1", rr[0]); end
    issue(0, 11'h010, 5'd16);
    for (int k = 0; k < 16; k++) begin
      total++;
      if (g_dut[0].a[k] !== 11'(16 + k)) begin
        bad++; $display("FAIL basic_addr[%0d] act=%h req=%h", k + 1, g_dut[0].a[k], 11'(16 + k));
      end
    end
    n = 0;
    while (!ov[0] && n < 10) begin cyc(); n++; end
    total++; if (n !== 2) begin bad++; $display("FAIL basic_latency act=%0d req=2", n); end
    for (int i = 0; i < 16; i++) begin
      total++;
      if (ov[0] !== 1'b1 || od[0] !== 32'h30 + 32'(3 * i) || ol[0] !== (i == 15)) begin
        bad++; $display("FAIL basic_word[%0d] act=%b/%h/%b req=1/%h/%b", i, ov[0], od[0], ol[0], 32'h30 + 32'(3 * i), (i == 15));
      end
      cyc();
    end
    exp_bd[0]++;
    total++; if (ov[0] !== 1'b0 || bd[0] !== 16'(exp_bd[0])) begin bad++; $display("FAIL basic_done act=%b/%0d req=0/%0d", ov[0], bd[0], exp_bd[0]); end
  endtask

  task automatic test_wrap();
    int n;
    logic [31:0] wexp [8] = '{32'h17F4, 32'h17F7, 32'h17FA, 32'h17FD, 32'h0, 32'h3, 32'h6, 32'h9};
    logic [10:0] aexp [8] = '{11'h7FC, 11'h7FD, 11'h7FE, 11'h7FF, 11'h000, 11'h001, 11'h002, 11'h003};
    out_ready = 1'b1;
    issue(0, 11'h7FC, 5'd8);
    for (int k = 0; k < 8; k++) begin
      total++;
      if (g_dut[0].a[k] !== aexp[k]) begin bad++; $display("FAIL wrap_addr[%0d] act=%h req=%h", k + 1, g_dut[0].a[k], aexp[k]); end
    end
    n = 0;
    while (!ov[0] && n < 10) begin cyc(); n++; end
    total++; if (n !== 2) begin bad++; $display("FAIL wrap_latency act=%0d req=2", n); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (ov[0] !== 1'b1 || od[0] !== wexp[i] || ol[0] !== (i == 7)) begin
        bad++; $display("FAIL wrap_word[%0d] act=%b/%h/%b req=1/%h/%b", i, ov[0], od[0], ol[0], wexp[i], (i == 7));
      end
      cyc();
    end
    exp_bd[0]++;
    total++; if (ov[0] !== 1'b0 || bd[0] !== 16'(exp_bd[0])) begin bad++; $display("FAIL wrap_done act=%b/%0d req=0/%0d", ov[0], bd[0], exp_bd[0]); end
  endtask

  task automatic test_backpressure();
    int n;
    int hs;
    int pat [7] = '{1, 0, 0, 1, 0, 1, 1};
    out_ready = 1'b0;
    issue(0, 11'h040, 5'd4);
    n = 0;
    while (!ov[0] && n < 10) begin cyc(); n++; end
    total++; if (n !== 2) begin bad++; $display("FAIL bp_latency act=%0d req=2", n); end
    hs = 0;
    for (int c = 0; c < 7; c++) begin
      out_ready = (pat[c] != 0);
      total++;
      if (ov[0] !== 1'b1 || od[0] !== 32'hC0 + 32'(3 * hs) || ol[0] !== (hs == 3)) begin
        bad++; $display("FAIL bp_cycle[%0d] act=%b/%h/%b req=1/%h/%b", c, ov[0], od[0], ol[0], 32'hC0 + 32'(3 * hs), (hs == 3));
      end
      cyc();
      if (pat[c] != 0) hs++;
    end
    out_ready = 1'b1;
    exp_bd[0]++;
    total++; if (ov[0] !== 1'b0 || bd[0] !== 16'(exp_bd[0])) begin bad++; $display("FAIL bp_done act=%b/%0d req=0/%0d", ov[0], bd[0], exp_bd[0]); end
  endtask

  task automatic test_len_edges();
    int n;
    int cnt;
    int nlast;
    int lastat;
    out_ready = 1'b1;
    // null burst
    issue(0, 11'h123, 5'd0);
    total++; if (rr[0] !== 1'b0 || ov[0] !== 1'b0 || bsy[0] !== 1'b0) begin bad++; $display("FAIL null_after_accept act=%b/%b/%b req=0/0/0", rr[0], ov[0], bsy[0]); end
    cyc();
    total++; if (rr[0] !== 1'b1 || ov[0] !== 1'b0) begin bad++; $display("FAIL null_ready_back act=%b/%b req=1/0", rr[0], ov[0]); end
    cyc();
    total++; if (ov[0] !== 1'b0 || bd[0] !== 16'(exp_bd[0])) begin bad++; $display("FAIL null_count act=%b/%0d req=0/%0d", ov[0], bd[0], exp_bd[0]); end
    // oversize burst clamps to 16
    issue(0, 11'h000, 5'd20);
    n = 0;
    while (!ov[0] && n < 10) begin cyc(); n++; end
    cnt = 0; nlast = 0; lastat = -1;
    while (ov[0] && cnt < 40) begin
      total++;
      if (od[0] !== 32'(3 * cnt)) begin bad++; $display("FAIL len20_word[%0d] act=%h req=%h", cnt, od[0], 32'(3 * cnt)); end
      if (ol[0]) begin nlast++; lastat = cnt; end
      cnt++;
      cyc();
    end
    total++; if (cnt !== 16) begin bad++; $display("FAIL len20_count act=%0d req=16", cnt); end
    total++; if (nlast !== 1 || lastat !== 15) begin bad++; $display("FAIL len20_last act=%0d@%0d req=1@15", nlast, lastat); end
    exp_bd[0]++;
    // single-word burst
    issue(0, 11'h005, 5'd1);
    n = 0;
    while (!ov[0] && n < 10) begin cyc(); n++; end
    total++; if (ov[0] !== 1'b1 || od[0] !== 32'h0F || ol[0] !== 1'b1) begin bad++; $display("FAIL len1_word act=%b/%h/%b req=1/0000000f/1", ov[0], od[0], ol[0]); end
    cyc();
    exp_bd[0]++;
    total++; if (ov[0] !== 1'b0 || bd[0] !== 16'(exp_bd[0])) begin bad++; $display("FAIL len1_done act=%b/%0d req=0/%0d", ov[0], bd[0], exp_bd[0]); end
  endtask

  task automatic test_back_to_back(input int u, input int lat);
    int n;
    sel = u;
    out_ready = 1'b1;
    total++; if (rr[u] !== 1'b1) begin bad++; $display("FAIL b2b_ready[lat%0d] act=%b req=1", lat, rr[u]); end
    req_base = 11'h100; req_len = 5'd2; req_valid = 1'b1;
    cyc();
    req_base = 11'h200; req_len = 5'd3;
    n = 0;
    while (!ov[u] && n < 10) begin cyc(); n++; end
    total++; if (n !== lat + 1) begin bad++; $display("FAIL b2b_first_latency[lat%0d] act=%0d req=%0d", lat, n, lat + 1); end
    for (int i = 0; i < 2; i++) begin
      total++;
      if (ov[u] !== 1'b1 || od[u] !== 32'h300 + 32'(3 * i) || ol[u] !== (i == 1)) begin
        bad++; $display("FAIL b2b_a_word[lat%0d][%0d] act=%b/%h/%b req=1/%h/%b", lat, i, ov[u], od[u], ol[u], 32'h300 + 32'(3 * i), (i == 1));
      end
      cyc();
    end
    total++; if (rr[u] !== 1'b1 || ov[u] !== 1'b0) begin bad++; $display("FAIL b2b_gap[lat%0d] act=%b/%b req=1/0", lat, rr[u], ov[u]); end
    cyc();
    req_valid = 1'b0;
    n = 0;
    while (!ov[u] && n < 10) begin cyc(); n++; end
    total++; if (n !== lat + 1) begin bad++; $display("FAIL b2b_second_latency[lat%0d] act=%0d req=%0d", lat, n, lat + 1); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (ov[u] !== 1'b1 || od[u] !== 32'h600 + 32'(3 * i) || ol[u] !== (i == 2)) begin
        bad++; $display("FAIL b2b_b_word[lat%0d][%0d] act=%b/%h/%b req=1/%h/%b", lat, i, ov[u], od[u], ol[u], 32'h600 + 32'(3 * i), (i == 2));
      end
      cyc();
    end
    exp_bd[u] += 2;
    total++; if (ov[u] !== 1'b0 || bd[u] !== 16'(exp_bd[u])) begin bad++; $display("FAIL b2b_done[lat%0d] act=%b/%0d req=0/%0d", lat, ov[u], bd[u], exp_bd[u]); end
  endtask

  task automatic test_reset_mid_drain();
    int n;
    int nz;
    out_ready = 1'b1;
    issue(0, 11'h000, 5'd16);
    n = 0;
    while (!ov[0] && n < 10) begin cyc(); n++; end
    repeat (5) cyc();
    total++; if (ov[0] !== 1'b1 || od[0] !== 32'h0F) begin bad++; $display("FAIL mid_pre_word act=%b/%h req=1/0000000f", ov[0], od[0]); end
    #1 rst = 1'b0;
    #1;
    nz = 0;
    for (int k = 0; k < 16; k++) if (g_dut[0].a[k] !== 11'd0) nz++;
    total++; if (ov[0] !== 1'b0 || ol[0] !== 1'b0 || bsy[0] !== 1'b0) begin bad++; $display("FAIL mid_abort act=%b/%b/%b req=0/0/0", ov[0], ol[0], bsy[0]); end
    total++; if (nz !== 0) begin bad++; $display("FAIL mid_addr_clear act=%0d_nonzero req=0", nz); end
    total++; if (rr[0] !== 1'b0 || bd[0] !== 16'd0 || od[0] !== 32'd0) begin bad++; $display("FAIL mid_ctrl act=%b/%0d/%h req=0/0/0", rr[0], bd[0], od[0]); end
    cyc();
    rst = 1'b1;
    exp_bd = '{0, 0, 0};
    cyc();
    total++; if (rr[0] !== 1'b1 || ov[0] !== 1'b0 || bd[0] !== 16'd0) begin bad++; $display("FAIL mid_release act=%b/%b/%0d req=1/0/0", rr[0], ov[0], bd[0]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_len_edges();
    test_back_to_back(0, 1);
    test_back_to_back(1, 0);
    test_back_to_back(2, 3);
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog");
  end

endmodule
